xadc_drp_arbiter: RTL and testbench

- Shares the single XADC DRP read port among `N_REQ` independent requesters, for example the joystick X/Y sampler, a temperature monitor and a supply monitor.
- Each transaction is one DRP read: round-robin grant, one-cycle `den` strobe, wait for `drdy` with a timeout, then a one-cycle response pulse to the winning requester.
- Sits between the requesting client blocks and the `xadc_wiz_0` DRP pins, all in the DRP clock domain.

---
 rtl/xadc_drp_arbiter.sv | 137 +++++++++++++
 tb/tb_xadc_drp_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/xadc_drp_arbiter.sv
// Round-robin arbiter sharing the XADC DRP read port among N_REQ requesters.
// Each grant issues one DRP read, waits for drdy (with timeout) and pulses rsp_valid to the owner.
module xadc_drp_arbiter #(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned TO_W    = 8
) (
    input  logic                 clk_100MHz,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req,
    input  logic [7*N_REQ-1:0]   req_addr,
    output logic [N_REQ-1:0]     gnt,
    output logic [N_REQ-1:0]     rsp_valid,
    output logic [15:0]          rsp_data,
    output logic                 rsp_err,
    output logic                 busy,
    output logic [6:0]           drp_daddr,
    output logic                 drp_den,
    output logic                 drp_dwe,
    output logic [15:0]          drp_di,
    input  logic                 drp_drdy,
    input  logic [15:0]          drp_do
);

    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned AW    = 7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t            state;
    logic [TO_W-1:0]   cnt;
    logic [IDX_W-1:0]  last;
    logic [IDX_W-1:0]  owner;
    logic [IDX_W-1:0]  win;
    logic              win_vld;
    logic [AW-1:0]     win_addr;

    assign drp_dwe = 1'b0;
    assign drp_di  = 16'h0000;

    // First set request bit searching upward from last+1, wrapping modulo N_REQ.
    always_comb begin
        int               idx;
        logic [IDX_W-1:0] cand;
        logic [N_REQ-1:0] sh;
        win     = '0;
        win_vld = 1'b0;
        idx     = 0;
        cand    = '0;
        sh      = '0;
        for (int k = 0; k < int'(N_REQ); k++) begin
            idx = int'(last) + 1 + k;
            if (idx >= int'(N_REQ)) begin
                idx = idx - int'(N_REQ);
            end
            cand = IDX_W'(idx);
            sh   = req >> cand;
            if (!win_vld && sh[0]) begin
                win     = cand;
                win_vld = 1'b1;
            end
        end
    end

    always_comb begin
        win_addr = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (win == IDX_W'(i)) begin
                win_addr = req_addr[AW*i +: AW];
            end
        end
    end

    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            gnt       <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            busy      <= 1'b0;
            drp_daddr <= '0;
            drp_den   <= 1'b0;
            cnt       <= '0;
            last      <= IDX_W'(N_REQ - 1);
            owner     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (win_vld) begin
                        gnt       <= N_REQ'(1) << win;
                        owner     <= win;
                        drp_daddr <= win_addr;
                        drp_den   <= 1'b1;
                        busy      <= 1'b1;
                        cnt       <= '0;
                        state     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    drp_den <= 1'b0;
                    // drdy has priority over a timeout on the same edge.
                    if (drp_drdy) begin
                        rsp_data  <= drp_do;
                        rsp_err   <= 1'b0;
                        rsp_valid <= gnt;
                        gnt       <= '0;
                        last      <= owner;
                        state     <= ST_RESP;
                    end else if (cnt == TO_W'(TIMEOUT - 1)) begin
                        rsp_data  <= '0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= gnt;
                        gnt       <= '0;
                        last      <= owner;
                        state     <= ST_RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    rsp_valid <= '0;
                    busy      <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xadc_drp_arbiter.sv
// Directed bench for xadc_drp_arbiter: single read, rotation, fairness,
// timeout, drdy/timeout collision and reset in the middle of a read.
module tb_xadc_drp_arbiter;

    localparam int unsigned N = 4;

    logic              clk_100MHz;
    logic              rst_n;
    logic [N-1:0]      req;
    logic [7*N-1:0]    req_addr;
    logic [N-1:0]      gnt;
    logic [N-1:0]      rsp_valid;
    logic [15:0]       rsp_data;
    logic              rsp_err;
    logic              busy;
    logic [6:0]        drp_daddr;
    logic              drp_den;
    logic              drp_dwe;
    logic [15:0]       drp_di;
    logic              drp_drdy;
    logic [15:0]       drp_do;

    int checks = 0;
    int errors = 0;

    xadc_drp_arbiter #(
        .N_REQ   (N),
        .TIMEOUT (16),
        .TO_W    (5)
    ) dut (
        .clk_100MHz (clk_100MHz),
        .rst_n      (rst_n),
        .req        (req),
        .req_addr   (req_addr),
        .gnt        (gnt),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .busy       (busy),
        .drp_daddr  (drp_daddr),
        .drp_den    (drp_den),
        .drp_dwe    (drp_dwe),
        .drp_di     (drp_di),
        .drp_drdy   (drp_drdy),
        .drp_do     (drp_do)
    );

    initial clk_100MHz = 1'b0;
    always #5 clk_100MHz = ~clk_100MHz;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_100MHz);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    // One read with req already presented in IDLE; drdy sampled lat edges after the grant edge.
    task automatic txn(input int g, input logic [6:0] a, input int lat, input logic [15:0] d);
        logic [N-1:0] oh;
        oh = N'(1) << g;
        tick();
        chk("grant_gnt", 32'(gnt), 32'(oh));
        chk("grant_den", 32'(drp_den), 32'd1);
        chk("grant_daddr", 32'(drp_daddr), 32'(a));
        chk("grant_busy", 32'(busy), 32'd1);
        tick();
        chk("wait_den_low", 32'(drp_den), 32'd0);
        chk("wait_gnt_held", 32'(gnt), 32'(oh));
        repeat (lat - 2) tick();
        chk("wait_no_rsp", 32'(rsp_valid), 32'd0);
        drp_drdy = 1'b1;
        drp_do   = d;
        tick();
        drp_drdy = 1'b0;
        drp_do   = 16'h0000;
        chk("rsp_valid", 32'(rsp_valid), 32'(oh));
        chk("rsp_data", 32'(rsp_data), 32'(d));
        chk("rsp_err", 32'(rsp_err), 32'd0);
        chk("rsp_gnt_low", 32'(gnt), 32'd0);
        tick();
        chk("resp_valid_low", 32'(rsp_valid), 32'd0);
        chk("resp_busy_low", 32'(busy), 32'd0);
        chk("resp_data_hold", 32'(rsp_data), 32'(d));
    endtask

    initial begin
        rst_n    = 1'b0;
        req      = '0;
        req_addr = {7'h06, 7'h00, 7'h17, 7'h16};
        drp_drdy = 1'b0;
        drp_do   = 16'h0000;
        #3;
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_den", 32'(drp_den), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_daddr", 32'(drp_daddr), 32'd0);
        chk("rst_dwe_di", {15'd0, drp_dwe, drp_di}, 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;

        // Single read
        req = 4'b0001;
        txn(0, 7'h16, 4, 16'hABC0);
        req = 4'b0000;
        tick();
        chk("idle_after_single", 32'(busy), 32'd0);

        // Rotation with all requests held
        do_reset();
        req = 4'b1111;
        txn(0, 7'h16, 3, 16'h0001);
        txn(1, 7'h17, 2, 16'h0002);
        txn(2, 7'h00, 5, 16'h0003);
        txn(3, 7'h06, 2, 16'h0004);
        txn(0, 7'h16, 2, 16'h0005);

        // Fairness between two held requesters
        do_reset();
        req = 4'b0011;
        txn(0, 7'h16, 2, 16'h1111);
        txn(1, 7'h17, 2, 16'h2222);
        txn(0, 7'h16, 2, 16'h3333);
        txn(1, 7'h17, 2, 16'h4444);

        // Timeout after a good read so rsp_data visibly clears
        do_reset();
        req = 4'b0001;
        txn(0, 7'h16, 4, 16'hABC0);
        tick();
        chk("to_den", 32'(drp_den), 32'd1);
        repeat (15) tick();
        chk("to_not_early", 32'(rsp_valid), 32'd0);
        tick();
        chk("to_valid", 32'(rsp_valid), 32'b0001);
        chk("to_err", 32'(rsp_err), 32'd1);
        chk("to_data", 32'(rsp_data), 32'd0);
        req = 4'b0000;
        tick();
        tick();
        tick();
        drp_drdy = 1'b1;
        drp_do   = 16'hBEEF;
        tick();
        drp_drdy = 1'b0;
        drp_do   = 16'h0000;
        chk("late_drdy_valid", 32'(rsp_valid), 32'd0);
        chk("late_drdy_busy", 32'(busy), 32'd0);
        chk("late_drdy_data", 32'(rsp_data), 32'd0);
        tick();
        chk("late_drdy_valid2", 32'(rsp_valid), 32'd0);

        // drdy on the timeout edge
        req = 4'b0001;
        tick();
        chk("coll_den", 32'(drp_den), 32'd1);
        repeat (15) tick();
        drp_drdy = 1'b1;
        drp_do   = 16'h1230;
        tick();
        drp_drdy = 1'b0;
        drp_do   = 16'h0000;
        chk("coll_valid", 32'(rsp_valid), 32'b0001);
        chk("coll_err", 32'(rsp_err), 32'd0);
        chk("coll_data", 32'(rsp_data), 32'h1230);
        req = 4'b0000;
        tick();

        // Reset two cycles into WAIT
        req = 4'b0001;
        tick();
        chk("mid_den", 32'(drp_den), 32'd1);
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_gnt", 32'(gnt), 32'd0);
        chk("mid_rst_den", 32'(drp_den), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_daddr", 32'(drp_daddr), 32'd0);
        chk("mid_rst_data", 32'(rsp_data), 32'd0);
        chk("mid_rst_err", 32'(rsp_err), 32'd0);
        req = 4'b0100;
        tick();
        tick();
        chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
        rst_n = 1'b1;
        txn(2, 7'h00, 3, 16'h5555);
        req = 4'b0000;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
